// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard controller: mux select codes,
// the "operand unused" Tuse code, and the Tnew saturating-decrement helper.
// Pure declarations, no logic; imported by the interface, sub-module and top.
package fwd_hazard_unit_pkg;

    // Select codes of the 3-input forwarding muxes. 00 makes the mux emit
    // zero and is never driven by this block.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_OWN  = 2'b01,
        SEL_M    = 2'b10,
        SEL_W    = 2'b11
    } fwd_sel_e;

    // Tuse value meaning the operand is not read at all.
    localparam logic [1:0] TUSE_NONE = 2'b11;

    // Tnew ages by one per stage and bottoms out at zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Purpose: bundle of decode info in, stall/forward selects out, for the hazard unit.
// Latency: n/a (wires only).
// Backpressure: stall is the only flow control; the datapath holds D while it is high.
// master = datapath side (drives decode info and the mult/div start pulse);
// slave  = fwd_hazard_unit (drives stall, the four mux selects and md_busy).
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [1:0]        d_tuse_rs;
    logic [1:0]        d_tuse_rt;
    logic [REG_AW-1:0] d_dst;
    logic [1:0]        d_tnew;
    logic              d_uses_md;
    logic              e_md_start;
    logic              e_md_is_div;

    logic              stall;
    logic [1:0]        sel_d_rs;
    logic [1:0]        sel_d_rt;
    logic [1:0]        sel_e_rs;
    logic [1:0]        sel_e_rt;
    logic              md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_uses_md,
        output e_md_start, e_md_is_div,
        input  stall, sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_uses_md,
        input  e_md_start, e_md_is_div,
        output stall, sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, md_busy
    );
endinterface

// File: rtl/fwd_hazard_unit_md_busy_counter.sv
// Purpose: HI/LO unit busy tracker; loads on a mult/div start, then counts down to 0.
// Latency: busy_o rises the cycle after start_i and stays up for the loaded count.
// Backpressure: none; the caller folds start_i/busy_o into its own stall.
// Ports: clk, rst_n (async, active low), start_i (one-cycle issue pulse),
//        is_div_i (qualifies start_i), busy_o (count != 0).
module md_busy_counter #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A start always reloads, even if a previous op were still counting;
    // the D-stage stall keeps that from happening in practice.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Purpose: Tuse/Tnew hazard and forwarding controller for the 5-stage pipeline.
// Latency: all outputs combinational from tracked E/M/W state plus current D inputs.
// Backpressure: asserts stall to freeze PC/D and inject a bubble into E.
// Ports: clk, rst_n (async, active low); hz (slave modport of fwd_hazard_unit_if)
//        carrying decode info in and stall / sel_d_* / sel_e_* / md_busy out.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave hz
);

    // E needs its source addresses for the E-stage muxes. Sources of older
    // stages are never consulted, and Tnew has no meaning once a result
    // reaches W, so those stages keep only what the match logic reads.
    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic [1:0]        tnew;
    } e_ent_t;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [1:0]        tnew;
    } m_ent_t;

    e_ent_t            e_q, e_d;
    m_ent_t            m_q, m_d;
    logic [REG_AW-1:0] w_dst_q, w_dst_d;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_raw;
    logic md_busy;

    // Register $0 is hard-wired, so a write to it never produces a hazard.
    function automatic logic hit(input logic [REG_AW-1:0] a,
                                 input logic [REG_AW-1:0] dst);
        return (a != '0) && (a == dst);
    endfunction

    // M entry's Tnew has already been aged by one on the E->M move, so it
    // directly says how many more cycles until the value exists.
    function automatic logic op_hazard(input logic [REG_AW-1:0] a,
                                       input logic [1:0]        tuse,
                                       input e_ent_t            e,
                                       input m_ent_t            m);
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (hit(a, e.dst) && (e.tnew > tuse)) ||
               (hit(a, m.dst) && (m.tnew > tuse));
    endfunction

    // Nearest producer wins. An M producer that is not ready yet is covered
    // by stall, but the select must still fall back to own-stage, not W.
    function automatic logic [1:0] src_sel(input logic [REG_AW-1:0] a,
                                           input m_ent_t            m,
                                           input logic [REG_AW-1:0] w_dst);
        if (hit(a, m.dst)) begin
            return (m.tnew == 2'd0) ? SEL_M : SEL_OWN;
        end
        if (hit(a, w_dst)) begin
            return SEL_W;
        end
        return SEL_OWN;
    endfunction

    // D has no mux leg for E results, so an E match always selects own-stage.
    function automatic logic [1:0] d_sel(input logic [REG_AW-1:0] a,
                                         input e_ent_t            e,
                                         input m_ent_t            m,
                                         input logic [REG_AW-1:0] w_dst);
        if (hit(a, e.dst)) begin
            return SEL_OWN;
        end
        return src_sel(a, m, w_dst);
    endfunction

    md_busy_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (hz.e_md_start),
        .is_div_i (hz.e_md_is_div),
        .busy_o   (md_busy)
    );

    always_comb begin
        stall_rs  = op_hazard(hz.d_rs, hz.d_tuse_rs, e_q, m_q);
        stall_rt  = op_hazard(hz.d_rt, hz.d_tuse_rt, e_q, m_q);
        // The start pulse counts as busy in its own cycle, before the counter loads.
        stall_md  = hz.d_uses_md && (md_busy || hz.e_md_start);
        stall_raw = stall_rs || stall_rt || stall_md;
    end

    // Pipeline advance: a stalled D turns into an all-zero bubble in E.
    always_comb begin
        e_d = '0;
        if (!stall_raw) begin
            e_d.rs   = hz.d_rs;
            e_d.rt   = hz.d_rt;
            e_d.dst  = hz.d_dst;
            e_d.tnew = hz.d_tnew;
        end
        m_d.dst  = e_q.dst;
        m_d.tnew = sat_dec(e_q.tnew);
        w_dst_d  = m_q.dst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_dst_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_dst_q <= w_dst_d;
        end
    end

    // Stall is masked by reset so a D instruction waiting on the start pulse
    // cannot hold the pipeline while reset is asserted.
    assign hz.stall    = rst_n && stall_raw;
    assign hz.md_busy  = md_busy;
    assign hz.sel_d_rs = d_sel(hz.d_rs, e_q, m_q, w_dst_q);
    assign hz.sel_d_rt = d_sel(hz.d_rt, e_q, m_q, w_dst_q);
    // A bubble in E has rs=rt=0, which never matches, so it selects own-stage.
    assign hz.sel_e_rs = src_sel(e_q.rs, m_q, w_dst_q);
    assign hz.sel_e_rt = src_sel(e_q.rt, m_q, w_dst_q);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose: directed self-checking bench for fwd_hazard_unit.
// Latency: outputs are checked 1-2 ns after inputs settle, mid-cycle.
// Backpressure: the bench holds the D instruction steady while stall is high.
module tb_fwd_hazard_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n;

    fwd_hazard_unit_if #(.REG_AW(5)) hz();

    fwd_hazard_unit #(
        .REG_AW     (5),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                         input int dst, input int tnew, input int uses_md);
        hz.d_rs      = 5'(rs);
        hz.d_rt      = 5'(rt);
        hz.d_tuse_rs = 2'(tuse_rs);
        hz.d_tuse_rt = 2'(tuse_rt);
        hz.d_dst     = 5'(dst);
        hz.d_tnew    = 2'(tnew);
        hz.d_uses_md = uses_md[0];
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    // Holds an HI/LO reader in D alongside the start pulse and counts stall cycles.
    task automatic md_run(input logic is_div, output int cycles);
        cycles = 0;
        set_d(0, 0, 3, 3, 8, 1, 1);
        hz.e_md_start  = 1'b1;
        hz.e_md_is_div = is_div;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hz.stall !== 1'b1) break;
            cycles++;
            tick();
            hz.e_md_start = 1'b0;
        end
        hz.e_md_start = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        nop();
        hz.e_md_start  = 1'b0;
        hz.e_md_is_div = 1'b0;
        repeat (2) tick();

        // Reset state.
        #1;
        chk("rst_stall",    hz.stall,    0);
        chk("rst_sel_d_rs", hz.sel_d_rs, 1);
        chk("rst_sel_d_rt", hz.sel_d_rt, 1);
        chk("rst_sel_e_rs", hz.sel_e_rs, 1);
        chk("rst_sel_e_rt", hz.sel_e_rt, 1);
        chk("rst_md_busy",  hz.md_busy,  0);
        rst_n = 1'b1;
        tick();

        // 1. Reset mid-run with the divider counter at 7.
        hz.e_md_start  = 1'b1;
        hz.e_md_is_div = 1'b1;
        tick();                     // count = 10
        hz.e_md_start = 1'b0;
        repeat (3) tick();          // 9, 8, 7
        set_d(0, 0, 3, 3, 0, 0, 1);
        #1;
        chk("mid_busy_before",  hz.md_busy, 1);
        chk("mid_stall_before", hz.stall,   1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall",    hz.stall,    0);
        chk("mid_rst_md_busy",  hz.md_busy,  0);
        chk("mid_rst_sel_d_rs", hz.sel_d_rs, 1);
        chk("mid_rst_sel_e_rs", hz.sel_e_rs, 1);
        #2;
        rst_n = 1'b1;
        nop();
        tick();
        chk("post_rst_busy", hz.md_busy, 0);
        flush();

        // 2. addu $3 (tnew=1) then consumer of $3 with tuse=1.
        set_d(1, 2, 1, 1, 3, 1, 0);
        tick();
        set_d(3, 2, 1, 1, 4, 1, 0);
        #1;
        chk("alu_alu_stall",    hz.stall,    0);
        chk("alu_alu_sel_d_rs", hz.sel_d_rs, 1);
        tick();
        nop();
        #1;
        chk("alu_alu_sel_e_rs", hz.sel_e_rs, 2);
        chk("alu_alu_sel_e_rt", hz.sel_e_rt, 1);
        flush();

        // Same pair with one nop between them.
        set_d(1, 2, 1, 1, 3, 1, 0);
        tick();
        nop();
        tick();
        set_d(3, 2, 1, 1, 4, 1, 0);
        #1;
        chk("gap_stall",    hz.stall,    0);
        chk("gap_sel_d_rs", hz.sel_d_rs, 2);
        tick();
        nop();
        #1;
        chk("gap_sel_e_rs", hz.sel_e_rs, 3);
        flush();

        // 3. lw $5 (tnew=2) then beq $5,$6 (tuse=0): two stall cycles.
        set_d(1, 0, 1, 3, 5, 2, 0);
        tick();
        set_d(5, 6, 0, 0, 0, 0, 0);
        #1;
        chk("lw_beq_stall1", hz.stall, 1);
        tick();
        #1;
        chk("lw_beq_stall2", hz.stall,    1);
        chk("lw_beq_sel_m",  hz.sel_d_rs, 1);
        tick();
        #1;
        chk("lw_beq_go",     hz.stall,    0);
        chk("lw_beq_sel_w",  hz.sel_d_rs, 3);
        chk("lw_beq_sel_rt", hz.sel_d_rt, 1);
        flush();

        // 4. lw $5 then addu $7,$5,$0 (tuse=1): one stall, then W forwards into E.
        set_d(1, 0, 1, 3, 5, 2, 0);
        tick();
        set_d(5, 0, 1, 1, 7, 1, 0);
        #1;
        chk("lw_alu_stall1", hz.stall, 1);
        tick();
        #1;
        chk("lw_alu_go", hz.stall, 0);
        tick();
        nop();
        #1;
        chk("lw_alu_sel_e_rs", hz.sel_e_rs, 3);
        flush();

        // 5. Load into $0, then read $0 with tuse=0.
        set_d(1, 0, 1, 3, 0, 2, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_stall_e",  hz.stall,    0);
        chk("r0_sel_d_rs", hz.sel_d_rs, 1);
        tick();
        #1;
        chk("r0_stall_m",  hz.stall,    0);
        chk("r0_sel_e_rs", hz.sel_e_rs, 1);
        chk("r0_sel_d_rt", hz.sel_d_rt, 1);
        flush();

        // 6. mult then mfhi: 1 + 5 stall cycles; div: 1 + 10.
        md_run(1'b0, n);
        chk("mul_stall_cycles", n, 6);
        chk("mul_busy_done", hz.md_busy, 0);
        flush();
        md_run(1'b1, n);
        chk("div_stall_cycles", n, 11);
        chk("div_busy_done", hz.md_busy, 0);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
